// File: rtl/fetch_unit.sv
// MIPS instruction-fetch stage: owns pc_F, fetches over a req/gnt/rvalid handshake, fills the F/D register.
// Optional misaligned-redirect trap (exc_adel/exc_badpc ports) is compiled in with `define FETCH_ADEL_CHECK_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC      = 32'h0000_3000,
  parameter int          IMEM_MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall_F,
  input  logic        redirect,
  input  logic [31:0] NPC,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_D,
  output logic [31:0] PC8_D,
  output logic        valid_D,
  output logic        fetch_timeout
`ifdef FETCH_ADEL_CHECK_EN
  ,
  output logic        exc_adel,
  output logic [31:0] exc_badpc
`endif
);

  localparam int              WD_W    = $clog2(IMEM_MAX_WAIT + 1);
  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(IMEM_MAX_WAIT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(IMEM_MAX_WAIT - 1);
  localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);
  localparam logic [WD_W-1:0] WD_ZERO = WD_W'(0);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_WAIT = 2'b10,
    S_HOLD = 2'b11
  } state_t;

  state_t          state_r;
  state_t          state_nx;
  logic [31:0]     pc_r;
  logic [31:0]     pc_nx;
  logic            redir_pend_r;
  logic            redir_pend_nx;
  logic [31:0]     redir_pc_r;
  logic [31:0]     redir_pc_nx;
  logic [31:0]     hold_data_r;
  logic [31:0]     hold_data_nx;
  logic [WD_W-1:0] wd_r;
  logic [WD_W-1:0] wd_nx;
  logic            timeout_nx;
  logic            load_s;
  logic [31:0]     load_data_s;
  logic [31:0]     npc_s;
  logic [31:0]     instr_nx;
  logic [31:0]     pc8_nx;
  logic            valid_nx;
  logic            stop_load_s;
  logic            stop_idle_s;

  // A redirect target is always word aligned before it can become a fetch address.
  assign npc_s = NPC & 32'hFFFF_FFFC;

`ifdef FETCH_ADEL_CHECK_EN
  logic        adel_nx;
  logic [31:0] badpc_nx;
  logic        stop_r;

  // Trap the first misaligned redirect target; the delay slot still completes.
  always_comb begin
    adel_nx  = exc_adel;
    badpc_nx = exc_badpc;
    if (!exc_adel && redirect && (NPC[1:0] != 2'b00)) begin
      adel_nx  = 1'b1;
      badpc_nx = NPC;
    end else begin
      adel_nx  = exc_adel;
      badpc_nx = exc_badpc;
    end
  end

  assign stop_load_s = adel_nx;
  assign stop_idle_s = stop_r;

  // Trap flags and the fetch-stop latch, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      exc_adel  <= 1'b0;
      exc_badpc <= 32'h0000_0000;
      stop_r    <= 1'b0;
    end else begin
      exc_adel  <= adel_nx;
      exc_badpc <= badpc_nx;
      stop_r    <= stop_r | (load_s & adel_nx);
    end
  end
`else
  assign stop_load_s = 1'b0;
  assign stop_idle_s = 1'b0;
`endif

  // Fetch FSM next state; a load happens on rvalid or on buffer release while D is free.
  always_comb begin
    state_nx     = state_r;
    load_s       = 1'b0;
    load_data_s  = 32'h0000_0000;
    hold_data_nx = hold_data_r;
    case (state_r)
      S_IDLE: begin
        if (stop_idle_s) state_nx = S_IDLE;
        else             state_nx = S_REQ;
      end
      S_REQ: begin
        if (imem_gnt) state_nx = S_WAIT;
        else          state_nx = S_REQ;
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          if (stall_F) begin
            hold_data_nx = imem_rdata;
            state_nx     = S_HOLD;
          end else begin
            load_s      = 1'b1;
            load_data_s = imem_rdata;
            state_nx    = stop_load_s ? S_IDLE : S_REQ;
          end
        end else begin
          state_nx = S_WAIT;
        end
      end
      S_HOLD: begin
        if (stall_F) begin
          state_nx = S_HOLD;
        end else begin
          load_s      = 1'b1;
          load_data_s = hold_data_r;
          state_nx    = stop_load_s ? S_IDLE : S_REQ;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // PC selection, pending-redirect bookkeeping and F/D register next values.
  always_comb begin
    pc_nx         = pc_r;
    redir_pend_nx = redir_pend_r;
    redir_pc_nx   = redir_pc_r;
    instr_nx      = instr_D;
    pc8_nx        = PC8_D;
    valid_nx      = valid_D;
    if (load_s) begin
      instr_nx      = load_data_s;
      pc8_nx        = pc_r + 32'd8;
      valid_nx      = 1'b1;
      redir_pend_nx = 1'b0;
      // A redirect seen on the load edge wins over an older pending one.
      if (redirect)          pc_nx = npc_s;
      else if (redir_pend_r) pc_nx = redir_pc_r;
      else                   pc_nx = pc_r + 32'd4;
    end else begin
      if (stall_F) valid_nx = valid_D;
      else         valid_nx = 1'b0;
      if (redirect) begin
        redir_pend_nx = 1'b1;
        redir_pc_nx   = npc_s;
      end else begin
        redir_pend_nx = redir_pend_r;
        redir_pc_nx   = redir_pc_r;
      end
    end
  end

  // Watchdog over cycles spent waiting for rvalid; the timeout flag is sticky.
  always_comb begin
    wd_nx      = wd_r;
    timeout_nx = fetch_timeout;
    if (state_r == S_WAIT) begin
      if (imem_rvalid) begin
        wd_nx      = WD_ZERO;
        timeout_nx = fetch_timeout;
      end else begin
        if (wd_r != WD_MAX) wd_nx = wd_r + WD_ONE;
        else                wd_nx = wd_r;
        if (wd_r >= WD_LAST) timeout_nx = 1'b1;
        else                 timeout_nx = fetch_timeout;
      end
    end else begin
      wd_nx      = wd_r;
      timeout_nx = fetch_timeout;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset_n) state_r <= S_IDLE;
    else          state_r <= state_nx;
  end

  // Datapath registers, including the registered memory request outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc_r          <= RESET_PC;
      redir_pend_r  <= 1'b0;
      redir_pc_r    <= 32'h0000_0000;
      hold_data_r   <= 32'h0000_0000;
      wd_r          <= WD_ZERO;
      fetch_timeout <= 1'b0;
      instr_D       <= 32'h0000_0000;
      PC8_D         <= 32'h0000_0000;
      valid_D       <= 1'b0;
      imem_req      <= 1'b0;
      imem_addr     <= {RESET_PC[31:2], 2'b00};
    end else begin
      pc_r          <= pc_nx;
      redir_pend_r  <= redir_pend_nx;
      redir_pc_r    <= redir_pc_nx;
      hold_data_r   <= hold_data_nx;
      wd_r          <= wd_nx;
      fetch_timeout <= timeout_nx;
      instr_D       <= instr_nx;
      PC8_D         <= pc8_nx;
      valid_D       <= valid_nx;
      imem_req      <= (state_nx == S_REQ);
      imem_addr     <= {pc_nx[31:2], 2'b00};
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: transaction-level reference model plus directed literal checks
// and a randomized phase with a reactive memory (random grant, random response latency).
module tb_fetch_unit;

  localparam logic [31:0] RPC  = 32'h0000_3000;
  localparam int          MAXW = 16;

  logic        clk = 1'b0;
  logic        reset_n, stall_F, redirect;
  logic [31:0] NPC;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt, imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr_D, PC8_D;
  logic        valid_D, fetch_timeout;
`ifdef FETCH_ADEL_CHECK_EN
  logic        exc_adel;
  logic [31:0] exc_badpc;
`endif

  fetch_unit #(.RESET_PC(RPC), .IMEM_MAX_WAIT(MAXW)) dut (
    .clk(clk), .reset_n(reset_n), .stall_F(stall_F), .redirect(redirect), .NPC(NPC),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_D(instr_D), .PC8_D(PC8_D), .valid_D(valid_D), .fetch_timeout(fetch_timeout)
`ifdef FETCH_ADEL_CHECK_EN
    , .exc_adel(exc_adel), .exc_badpc(exc_badpc)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // memory side
  int unsigned q_wait[$];
  logic [31:0] q_data[$];
  int          k_gnt_pct, k_wmin, k_wmax;
  logic [31:0] last_rdata;
  bit          granted;

  // reference model: a fetch is either not started, in flight at memory, or parked in a buffer
  logic [31:0] m_pc, m_pend_pc, m_buf, m_instr, m_pc8;
  bit          m_pend, m_warm, m_inflight, m_buf_v, m_valid, m_to;
  int          m_wd;
  bit          exp_req;

  // directed-test scratch
  logic [31:0] addrs[3];
  int          na, first_valid, nvalid, guard;
  logic [31:0] saved, held;
  int          r_st, r_rd, r_rst;
  logic [31:0] r_np;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    bit          load, req_now;
    logic [31:0] d;
    if (!reset_n) begin
      m_pc = RPC; m_pend = 0; m_pend_pc = 0; m_warm = 0; m_inflight = 0; m_buf_v = 0; m_buf = 0;
      m_instr = 0; m_pc8 = 0; m_valid = 0; m_wd = 0; m_to = 0;
      return;
    end
    load = 0; d = 0;
    req_now = m_warm && !m_inflight && !m_buf_v;
    if (m_inflight) begin
      if (imem_rvalid) begin
        m_inflight = 0; m_wd = 0;
        if (!stall_F) begin load = 1; d = imem_rdata; end
        else begin m_buf_v = 1; m_buf = imem_rdata; end
      end else begin
        m_wd++;
        if (m_wd >= MAXW) m_to = 1;
      end
    end else if (m_buf_v && !stall_F) begin
      load = 1; d = m_buf; m_buf_v = 0;
    end
    if (req_now && imem_gnt) m_inflight = 1;
    m_warm = 1;
    if (load) begin
      m_instr = d; m_pc8 = m_pc + 32'd8; m_valid = 1;
      if (redirect)    m_pc = NPC & 32'hFFFF_FFFC;
      else if (m_pend) m_pc = m_pend_pc & 32'hFFFF_FFFC;
      else             m_pc = m_pc + 32'd4;
      m_pend = 0;
    end else begin
      if (!stall_F) m_valid = 0;
      if (redirect) begin m_pend = 1; m_pend_pc = NPC; end
    end
  endtask

  // One clock: drive inputs on the falling edge, advance the model on the rising edge.
  task automatic step(input logic rst, input logic st, input logic rd, input logic [31:0] np);
    @(negedge clk);
    reset_n = rst; stall_F = st; redirect = rd; NPC = np;
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    if (q_wait.size() > 0) begin
      if (q_wait[0] == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = q_data[0];
        last_rdata  = q_data[0];
        void'(q_wait.pop_front());
        void'(q_data.pop_front());
      end else begin
        q_wait[0] = q_wait[0] - 1;
      end
    end
    imem_gnt = ($urandom_range(99) < k_gnt_pct);
    granted  = imem_req && imem_gnt && rst;
    if (granted) begin
      q_wait.push_back($urandom_range(k_wmax, k_wmin));
      q_data.push_back($urandom);
    end
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic dreset();
    q_wait.delete(); q_data.delete();
    step(1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      exp_req = m_warm && !m_inflight && !m_buf_v;
      check32("imem_req", imem_req, exp_req);
      if (exp_req) check32("imem_addr", imem_addr, m_pc);
      check32("valid_D", valid_D, m_valid);
      check32("instr_D", instr_D, m_instr);
      check32("PC8_D", PC8_D, m_pc8);
      check32("fetch_timeout", fetch_timeout, m_to);
`ifdef FETCH_ADEL_CHECK_EN
      check32("exc_adel", exc_adel, 1'b0);
`endif
    end
  end

  initial begin
    reset_n = 0; stall_F = 0; redirect = 0; NPC = 0;
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0; last_rdata = 0;
    k_gnt_pct = 100; k_wmin = 0; k_wmax = 0;
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk_en = 1;
    check32("rst_valid_D", valid_D, 1'b0);
    check32("rst_instr_D", instr_D, 32'h0);
    check32("rst_PC8_D", PC8_D, 32'h0);
    check32("rst_imem_req", imem_req, 1'b0);
    check32("rst_timeout", fetch_timeout, 1'b0);

    // zero-wait throughput and address sequence
    na = 0; first_valid = -1; nvalid = 0;
    for (int i = 0; i < 20; i++) begin
      if (imem_req && na < 3) begin addrs[na] = imem_addr; na++; end
      step(1'b1, 1'b0, 1'b0, 32'h0);
      if (valid_D && first_valid < 0) begin
        first_valid = i;
        check32("first_PC8_D", PC8_D, 32'h0000_3008);
      end
      if (first_valid >= 0 && i < first_valid + 10) nvalid += valid_D;
    end
    check32("addr0", addrs[0], 32'h0000_3000);
    check32("addr1", addrs[1], 32'h0000_3004);
    check32("addr2", addrs[2], 32'h0000_3008);
    check32("rate_2cyc", nvalid, 5);

    // response arrives while D is stalled for three cycles
    guard = 0;
    do begin step(1'b1, 1'b0, 1'b0, 32'h0); guard++; end while (!granted && guard < 10);
    check32("stall_setup", granted, 1'b1);
    saved = instr_D;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      check32("stall_no_req", imem_req, 1'b0);
      check32("stall_instr_hold", instr_D, saved);
    end
    held = last_rdata;
    step(1'b1, 1'b0, 1'b0, 32'h0);
    check32("held_word", instr_D, held);
    check32("held_valid", valid_D, 1'b1);

    // redirect seen before the delay slot returns (one-cycle memory latency)
    k_wmin = 1; k_wmax = 1;
    dreset();
    guard = 0;
    do begin step(1'b1, 1'b0, 1'b0, 32'h0); guard++; end
    while (!(valid_D && PC8_D == 32'h0000_300C) && guard < 40);
    check32("br_in_D", PC8_D, 32'h0000_300C);
    step(1'b1, 1'b0, 1'b1, 32'h0000_3100);
    guard = 0;
    do begin step(1'b1, 1'b0, 1'b0, 32'h0); guard++; end while (!valid_D && guard < 20);
    check32("dslot_PC8", PC8_D, 32'h0000_3010);
    check32("dslot_valid", valid_D, 1'b1);
    check32("target_addr", imem_addr, 32'h0000_3100);
    guard = 0;
    do begin step(1'b1, 1'b0, 1'b0, 32'h0); guard++; end while (!valid_D && guard < 20);
    check32("target_PC8", PC8_D, 32'h0000_3108);

    // redirect on the very edge the delay slot loads (zero-wait)
    k_wmin = 0; k_wmax = 0;
    dreset();
    guard = 0;
    do begin step(1'b1, 1'b0, 1'b0, 32'h0); guard++; end
    while (!(valid_D && PC8_D == 32'h0000_300C) && guard < 40);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b1, 32'h0000_3200);
    check32("same_edge_PC8", PC8_D, 32'h0000_3010);
    check32("same_edge_req", imem_req, 1'b1);
    check32("same_edge_addr", imem_addr, 32'h0000_3200);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    check32("tgt2_PC8", PC8_D, 32'h0000_3208);
    check32("tgt2_next_addr", imem_addr, 32'h0000_3204);

    // reset while waiting; the stale response lands in S_IDLE
    k_wmin = 1; k_wmax = 1;
    dreset();
    guard = 0;
    do begin step(1'b1, 1'b0, 1'b0, 32'h0); guard++; end while (!granted && guard < 10);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    check32("midrst_valid", valid_D, 1'b0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    check32("stale_seen", imem_rvalid, 1'b1);
    check32("post_rst_req", imem_req, 1'b1);
    check32("post_rst_addr", imem_addr, 32'h0000_3000);
    check32("post_rst_valid", valid_D, 1'b0);
    guard = 0;
    do begin step(1'b1, 1'b0, 1'b0, 32'h0); guard++; end while (!valid_D && guard < 20);
    check32("fresh_word", instr_D, last_rdata);
    check32("fresh_PC8", PC8_D, 32'h0000_3008);

    // watchdog boundary: 15 silent cycles are fine, 16 trip the flag
    k_wmin = 15; k_wmax = 15;
    dreset();
    guard = 0;
    do begin step(1'b1, 1'b0, 1'b0, 32'h0); guard++; end while (!valid_D && guard < 60);
    check32("wd15_valid", valid_D, 1'b1);
    check32("wd15_timeout", fetch_timeout, 1'b0);
    k_wmin = 16; k_wmax = 16;
    guard = 0;
    do begin step(1'b1, 1'b0, 1'b0, 32'h0); guard++; end while (!valid_D && guard < 60);
    check32("wd16_timeout", fetch_timeout, 1'b1);
    check32("wd16_word", instr_D, last_rdata);
    k_wmin = 0; k_wmax = 0;
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
    check32("wd_sticky", fetch_timeout, 1'b1);
    dreset();
    check32("wd_rst_clear", fetch_timeout, 1'b0);

    // randomized traffic
    k_gnt_pct = 70;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(19) == 0) begin k_wmin = 14; k_wmax = 17; end
      else begin k_wmin = 0; k_wmax = 3; end
      r_rst = ($urandom_range(299) != 0) ? 1 : 0;
      r_st  = ($urandom_range(99) < 30) ? 1 : 0;
      r_rd  = ($urandom_range(99) < 15) ? 1 : 0;
      r_np  = $urandom;
`ifdef FETCH_ADEL_CHECK_EN
      r_np  = r_np & 32'hFFFF_FFFC;
`endif
      step(r_rst[0], r_st[0], r_rd[0], r_np);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
